// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bundle for sync_fifo_prog: data handshake, thresholds, status and error flags.
// master drives requests and thresholds; slave (the FIFO) drives data-out and status.
interface sync_fifo_prog_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic [ADDR_WIDTH:0]   af_thresh;
   logic [ADDR_WIDTH:0]   ae_thresh;
   logic                  err_clr;
   logic [ADDR_WIDTH:0]   level;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
      input  rd_data, rd_valid, level, full, empty, almost_full, almost_empty,
             overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
      output rd_data, rd_valid, level, full, empty, almost_full, almost_empty,
             overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-flags, fill level and sticky error flags; read latency 1 (FWFT=0) or 0 (FWFT=1).
// No backpressure stall: writes at full and reads at empty are dropped and recorded as overflow/underflow.
module sync_fifo_prog #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter bit FWFT       = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   sync_fifo_prog_if.slave bus
);
   localparam int                  DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   level_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  full_w;
   logic                  empty_w;
   logic                  wr_acc;
   logic                  rd_acc;

   // Acceptance is judged on the level held at this edge, so a simultaneous
   // read never makes room for a write at full (and vice versa at empty).
   assign full_w  = (level_q == DEPTH_L);
   assign empty_w = (level_q == '0);
   assign wr_acc  = bus.wr_en && !full_w;
   assign rd_acc  = bus.rd_en && !empty_w;

   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wr_ptr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr    <= rd_ptr + 1'b1;
            rd_data_q <= mem[rd_ptr];
         end
         rd_valid_q <= rd_acc;

         case ({wr_acc, rd_acc})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase

         // A new error in the same cycle as err_clr stays visible.
         if (bus.wr_en && full_w) begin
            overflow_q <= 1'b1;
         end else if (bus.err_clr) begin
            overflow_q <= 1'b0;
         end
         if (bus.rd_en && empty_w) begin
            underflow_q <= 1'b1;
         end else if (bus.err_clr) begin
            underflow_q <= 1'b0;
         end
      end
   end

   assign bus.rd_data      = FWFT ? mem[rd_ptr] : rd_data_q;
   assign bus.rd_valid     = FWFT ? !empty_w : rd_valid_q;
   assign bus.level        = level_q;
   assign bus.full         = full_w;
   assign bus.empty        = empty_w;
   assign bus.almost_full  = (level_q >= bus.af_thresh);
   assign bus.almost_empty = (level_q <= bus.ae_thresh);
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and checks both
// every cycle against a queue-based model, plus directed scenarios with literal expectations.
module tb_sync_fifo_prog;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic [4:0] af_thresh = 5'd12;
   logic [4:0] ae_thresh = 5'd3;
   int         vectors = 0;
   int         miscompares = 0;
   bit         chk_en = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if0 ();
   sync_fifo_prog_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if1 ();

   assign if0.wr_en     = wr_en;
   assign if0.wr_data   = wr_data;
   assign if0.rd_en     = rd_en;
   assign if0.err_clr   = err_clr;
   assign if0.af_thresh = af_thresh;
   assign if0.ae_thresh = ae_thresh;
   assign if1.wr_en     = wr_en;
   assign if1.wr_data   = wr_data;
   assign if1.rd_en     = rd_en;
   assign if1.err_clr   = err_clr;
   assign if1.af_thresh = af_thresh;
   assign if1.ae_thresh = ae_thresh;

   sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: contents as a queue, errors as booleans.
   logic [7:0] mq[$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;
   logic [7:0] m_rd_data = 8'h00;
   logic       m_rd_valid = 1'b0;

   always @(posedge clk) begin
      bit was_full, was_empty, wa, ra;
      if (rst) begin
         mq.delete();
         m_ovf      = 1'b0;
         m_unf      = 1'b0;
         m_rd_data  = 8'h00;
         m_rd_valid = 1'b0;
      end else begin
         was_full  = (mq.size() == 16);
         was_empty = (mq.size() == 0);
         wa = wr_en && !was_full;
         ra = rd_en && !was_empty;
         m_rd_valid = ra;
         if (ra) m_rd_data = mq.pop_front();
         if (wa) mq.push_back(wr_data);
         if (wr_en && was_full) m_ovf = 1'b1;
         else if (err_clr) m_ovf = 1'b0;
         if (rd_en && was_empty) m_unf = 1'b1;
         else if (err_clr) m_unf = 1'b0;
      end
   end

   always @(negedge clk) begin
      int n;
      if (chk_en) begin
         n = mq.size();
         chk("level0", 32'(if0.level), n);
         chk("level1", 32'(if1.level), n);
         chk("full0", 32'(if0.full), 32'(n == 16));
         chk("full1", 32'(if1.full), 32'(n == 16));
         chk("empty0", 32'(if0.empty), 32'(n == 0));
         chk("empty1", 32'(if1.empty), 32'(n == 0));
         chk("afull0", 32'(if0.almost_full), 32'(n >= int'(af_thresh)));
         chk("afull1", 32'(if1.almost_full), 32'(n >= int'(af_thresh)));
         chk("aempty0", 32'(if0.almost_empty), 32'(n <= int'(ae_thresh)));
         chk("aempty1", 32'(if1.almost_empty), 32'(n <= int'(ae_thresh)));
         chk("ovf0", 32'(if0.overflow), 32'(m_ovf));
         chk("ovf1", 32'(if1.overflow), 32'(m_ovf));
         chk("unf0", 32'(if0.underflow), 32'(m_unf));
         chk("unf1", 32'(if1.underflow), 32'(m_unf));
         chk("rd_valid0", 32'(if0.rd_valid), 32'(m_rd_valid));
         chk("rd_data0", 32'(if0.rd_data), 32'(m_rd_data));
         chk("rd_valid1", 32'(if1.rd_valid), 32'(n != 0));
         if (n != 0) chk("rd_data1", 32'(if1.rd_data), 32'(mq[0]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en = 1'b1; rd_en = 1'b0; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1; wr_en = 1'b0;
      step();
      rd_en = 1'b0;
   endtask

   initial begin
      int wp;
      logic [7:0] exp_d;

      // Reset state
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_empty", 32'(if0.empty), 32'd1);
      chk("rst_level", 32'(if0.level), 32'd0);
      chk("rst_aempty", 32'(if0.almost_empty), 32'd1);
      chk("rst_afull", 32'(if0.almost_full), 32'd0);
      chk("rst_rd_valid0", 32'(if0.rd_valid), 32'd0);
      chk("rst_rd_data0", 32'(if0.rd_data), 32'd0);
      chk("rst_rd_valid1", 32'(if1.rd_valid), 32'd0);
      af_thresh = 5'd0;
      #1;
      chk("af_zero_empty", 32'(if0.almost_full), 32'd1);
      af_thresh = 5'd12;

      // Fill to full, watching threshold crossings
      for (int i = 0; i < 16; i++) begin
         push(8'h10 + 8'((i + 1) % 16));
         chk("fill_level", 32'(if0.level), 32'(i + 1));
         chk("fill_aempty", 32'(if0.almost_empty), 32'((i + 1) <= 3));
         chk("fill_afull", 32'(if0.almost_full), 32'((i + 1) >= 12));
      end
      chk("full_flag", 32'(if0.full), 32'd1);
      push(8'hEE);
      chk("ovf_set", 32'(if0.overflow), 32'd1);
      chk("ovf_level", 32'(if0.level), 32'd16);

      // Drain in order
      for (int i = 0; i < 16; i++) begin
         pop();
         exp_d = 8'h10 + 8'((i + 1) % 16);
         chk("drain_data", 32'(if0.rd_data), 32'(exp_d));
         chk("drain_valid", 32'(if0.rd_valid), 32'd1);
         chk("drain_aempty", 32'(if0.almost_empty), 32'((15 - i) <= 3));
         chk("drain_afull", 32'(if0.almost_full), 32'((15 - i) >= 12));
      end
      step();
      chk("valid_one_cycle", 32'(if0.rd_valid), 32'd0);
      chk("drain_empty", 32'(if0.empty), 32'd1);

      // Underflow and error clear
      pop();
      chk("unf_set", 32'(if0.underflow), 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("unf_clr", 32'(if0.underflow), 32'd0);
      chk("ovf_clr", 32'(if0.overflow), 32'd0);
      rd_en = 1'b1; err_clr = 1'b1;
      step();
      rd_en = 1'b0; err_clr = 1'b0;
      chk("unf_set_wins", 32'(if0.underflow), 32'd1);

      // FWFT fall-through
      push(8'hA5);
      chk("fwft_valid", 32'(if1.rd_valid), 32'd1);
      chk("fwft_data", 32'(if1.rd_data), 32'hA5);
      chk("std_no_valid", 32'(if0.rd_valid), 32'd0);
      step();
      chk("fwft_hold", 32'(if1.rd_valid), 32'd1);
      pop();
      chk("fwft_empty", 32'(if1.empty), 32'd1);
      chk("fwft_valid_off", 32'(if1.rd_valid), 32'd0);
      chk("std_pop_data", 32'(if0.rd_data), 32'hA5);

      // Simultaneous read/write at level 8 with pointer wrap
      for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h40 + 8'(i);
         step();
         chk("rw_level", 32'(if0.level), 32'd8);
         exp_d = (i < 8) ? 8'h30 + 8'(i) : 8'h40 + 8'(i - 8);
         chk("rw_data", 32'(if0.rd_data), 32'(exp_d));
      end
      wr_en = 1'b0; rd_en = 1'b0;
      for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
      chk("rw_full", 32'(if0.full), 32'd1);
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hFF;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("full_rw_level", 32'(if0.level), 32'd15);
      chk("full_rw_ovf", 32'(if0.overflow), 32'd1);

      // Reset mid-burst
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < 10; i++) push(8'h70 + 8'(i));
      wr_en = 1'b1; wr_data = 8'h7A; rst = 1'b1;
      step();
      rst = 1'b0; wr_en = 1'b0;
      chk("mrst_level", 32'(if0.level), 32'd0);
      chk("mrst_empty", 32'(if0.empty), 32'd1);
      chk("mrst_ovf", 32'(if0.overflow), 32'd0);
      chk("mrst_unf", 32'(if0.underflow), 32'd0);
      chk("mrst_rd_data", 32'(if0.rd_data), 32'd0);
      push(8'hC1); push(8'hC2); push(8'hC3);
      for (int i = 0; i < 3; i++) begin
         pop();
         chk("mrst_readback", 32'(if0.rd_data), 32'(8'hC1 + 8'(i)));
      end

      // Randomised traffic with drifting fill bias
      for (int c = 0; c < 3000; c++) begin
         case ((c / 150) % 3)
            0:       wp = 75;
            1:       wp = 25;
            default: wp = 50;
         endcase
         rst     = ($urandom_range(0, 199) == 0);
         wr_en   = ($urandom_range(0, 99) < wp);
         rd_en   = ($urandom_range(0, 99) < (100 - wp));
         err_clr = ($urandom_range(0, 15) == 0);
         wr_data = 8'($urandom);
         if (c % 97 == 0) begin
            af_thresh = 5'($urandom_range(0, 20));
            ae_thresh = 5'($urandom_range(0, 20));
         end
         step();
      end
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
      step();
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
